// File: rtl/gen_pipe_arb.sv
// gen_pipe_arb: round-robin arbiter sharing one fixed-latency pipe
// between N_REQ requesters, with per-requester in-flight credit caps.
module gen_pipe_arb #(
  parameter int N_REQ       = 4,
  parameter int DEPTH       = 2,
  parameter int DAT_W       = 4,
  parameter int MAX_OUTS    = 2,
  parameter bit LOW_PWR_OPT = 1'b1,
  parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*DAT_W-1:0] req_dat,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   out_vld,
  output logic [DAT_W-1:0]       out_dat,
  output logic [ID_W-1:0]        out_id,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0]   CMAX = CW'(MAX_OUTS);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [CW-1:0]    cnt [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] inc;
  logic [N_REQ-1:0] dec;
  logic [ID_W-1:0]  win;
  logic             acc;
  logic [DAT_W-1:0] win_dat;

  logic [DEPTH-1:0] s_vld;
  logic [DAT_W-1:0] s_dat [DEPTH];
  logic [ID_W-1:0]  s_id  [DEPTH];

  // eligible = requesting and still holding a free credit
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_vld[i] && (cnt[i] < CMAX);
  end

  // round-robin scan starting at rr_ptr; first eligible wins
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (gnt == '0 && elig[j]) begin
        gnt[j] = 1'b1;
        win    = ID_W'(j);
      end
    end
  end

  assign req_rdy = rst_n ? gnt : '0;
  assign acc     = |req_rdy;
  assign win_dat = req_dat[int'(win)*DAT_W +: DAT_W];

  // credit bookkeeping strobes per requester
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      inc[i] = acc && (win == ID_W'(i));
      dec[i] = out_vld && (out_id == ID_W'(i));
    end
  end

  // pointer moves just past the winner, holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (acc)
      rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
  end

  // valid chain always shifts so bubbles propagate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld <= '0;
    end else begin
      s_vld[0] <= acc;
      for (int k = 1; k < DEPTH; k++)
        s_vld[k] <= s_vld[k-1];
    end
  end

  // payload chain; optionally only moves behind a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        s_dat[k] <= '0;
        s_id[k]  <= '0;
      end
    end else begin
      if (!LOW_PWR_OPT || acc) begin
        s_dat[0] <= win_dat;
        s_id[0]  <= win;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (!LOW_PWR_OPT || s_vld[k-1]) begin
          s_dat[k] <= s_dat[k-1];
          s_id[k]  <= s_id[k-1];
        end
      end
    end
  end

  // in-flight counters; simultaneous accept and retire cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign out_vld = s_vld[DEPTH-1];
  assign out_dat = s_dat[DEPTH-1];
  assign out_id  = s_id[DEPTH-1];
  assign busy    = |s_vld;

endmodule

// File: tb/tb_gen_pipe_arb.sv
// tb_gen_pipe_arb: directed stimulus with a scoreboard queue;
// a negedge monitor pops expected {id,dat} on every out_vld.
module tb_gen_pipe_arb;

  localparam int N = 4;
  localparam int D = 2;
  localparam int W = 4;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_vld;
  logic [N*W-1:0] req_dat;
  logic [N-1:0] req_rdy;
  logic         out_vld;
  logic [W-1:0] out_dat;
  logic [1:0]   out_id;
  logic         busy;

  int ncmp = 0;
  int nerr = 0;
  logic [5:0] q [$];
  logic [5:0] exp_item;

  always #5 clk = ~clk;

  gen_pipe_arb #(
    .N_REQ(N), .DEPTH(D), .DAT_W(W),
    .MAX_OUTS(M), .LOW_PWR_OPT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_dat(req_dat),
    .req_rdy(req_rdy), .out_vld(out_vld),
    .out_dat(out_dat), .out_id(out_id),
    .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // drive one cycle; er = hand-computed grant, eb = busy (-1 skip)
  task automatic step(input logic [3:0] v,
                      input logic [15:0] d,
                      input logic [3:0] er,
                      input int eb);
    req_vld = v;
    req_dat = d;
    @(negedge clk);
    chk("req_rdy", 32'(req_rdy), 32'(er));
    if (eb >= 0) chk("busy", 32'(busy), 32'(eb));
    for (int i = 0; i < N; i++)
      if (er[i]) q.push_back({2'(i), d[i*W +: W]});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(4'h0, 16'h0, 4'h0, -1);
  endtask

  // output monitor: every valid beat must match the queue head
  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      ncmp++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL out_unexpected: got id=%0d dat=%0h want none",
                 out_id, out_dat);
      end else begin
        exp_item = q.pop_front();
        if ({out_id, out_dat} !== exp_item) begin
          nerr++;
          $display("FAIL out_beat: got id=%0d dat=%0h want id=%0d dat=%0h",
                   out_id, out_dat, exp_item[5:4], exp_item[3:0]);
        end
      end
    end
  end

  // a retire must never hit an empty counter
  always @(posedge clk) begin
    if (rst_n && out_vld) begin
      ncmp++;
      if (dut.cnt[out_id] == '0) begin
        nerr++;
        $display("FAIL cnt_underflow: got cnt[%0d]=0 want >0", out_id);
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    req_vld = 4'hF;
    req_dat = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_dat", 32'(out_dat), 32'd0);
    chk("rst_out_id",  32'(out_id),  32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    #9;
    rst_n   = 1'b1;
    req_vld = 4'h0;
    @(posedge clk);
    #1;

    // reset and latency: single beat from req 2
    step(4'b0100, 16'h0A00, 4'b0100, 0);
    step(4'b0000, 16'h0000, 4'b0000, 1);
    step(4'b0000, 16'h0000, 4'b0000, 1);
    step(4'b0000, 16'h0000, 4'b0000, 0);

    // pointer at 3, only 0 and 2 valid: 0, 2, 0
    step(4'b0101, 16'h0201, 4'b0001, -1);
    step(4'b0101, 16'h0403, 4'b0100, -1);
    step(4'b0101, 16'h0605, 4'b0001, -1);
    idle(3);

    // req 1 accepted while its earlier beat retires
    step(4'b0010, 16'h0070, 4'b0010, -1);
    step(4'b0000, 16'h0000, 4'b0000, -1);
    step(4'b0010, 16'h0080, 4'b0010, -1);
    step(4'b0010, 16'h0090, 4'b0010, -1);
    step(4'b0010, 16'h00B0, 4'b0000, -1);
    step(4'b0010, 16'h00A0, 4'b0010, -1);
    idle(3);

    // credit cap on req 0: acc, acc, stall, repeating
    step(4'b0001, 16'h0001, 4'b0001, -1);
    step(4'b0001, 16'h0002, 4'b0001, -1);
    step(4'b0001, 16'h000F, 4'b0000, -1);
    step(4'b0001, 16'h0003, 4'b0001, -1);
    step(4'b0001, 16'h0004, 4'b0001, -1);
    step(4'b0001, 16'h000E, 4'b0000, -1);
    step(4'b0001, 16'h0005, 4'b0001, -1);
    step(4'b0001, 16'h0006, 4'b0001, -1);
    step(4'b0001, 16'h000D, 4'b0000, -1);
    idle(3);

    // all requesting, pointer at 1: 1,2,3,0,1,2,3,0
    step(4'b1111, 16'h3210, 4'b0010, -1);
    step(4'b1111, 16'h7654, 4'b0100, -1);
    step(4'b1111, 16'hBA98, 4'b1000, -1);
    step(4'b1111, 16'hFEDC, 4'b0001, -1);
    step(4'b1111, 16'h1357, 4'b0010, -1);
    step(4'b1111, 16'h2468, 4'b0100, -1);
    step(4'b1111, 16'h9ACE, 4'b1000, -1);
    step(4'b1111, 16'hBDF0, 4'b0001, -1);
    idle(3);

    // async reset with two beats in flight
    step(4'b0011, 16'h00C5, 4'b0010, -1);
    step(4'b0011, 16'h00D6, 4'b0001, -1);
    chk("pre_rst_out_vld", 32'(out_vld), 32'd1);
    chk("pre_rst_out_id",  32'(out_id),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_busy",    32'(busy),    32'd0);
    chk("mid_rst_out_dat", 32'(out_dat), 32'd0);
    chk("mid_rst_out_id",  32'(out_id),  32'd0);
    chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(4'b0011, 16'h0021, 4'b0001, 0);
    step(4'b0001, 16'h0003, 4'b0001, 1);
    step(4'b0001, 16'h0004, 4'b0000, -1);
    idle(4);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/gen_pipe_arb.md
Name: gen_pipe_arb

Overview:
Round-robin arbiter and scheduler that shares one fixed-latency, non-stalling delay pipe between N requesters.
- Each accepted request is tagged with its requester ID and travels DEPTH stages. It emerges as out_vld/out_dat/out_id.
- A per-requester outstanding-transaction counter caps how many beats each requester may have in flight.
- Sits between multiple producers and a shared fixed-latency resource model. Consumers demultiplex results by out_id.

Parameters:
N_REQ, 4, number of requesters (>=2)
DEPTH, 2, pipe latency in cycles (>=1)
DAT_W, 4, data width per requester
MAX_OUTS, 2, max in-flight beats per requester (1..DEPTH+1)
LOW_PWR_OPT, 1'b1, when 1, data/ID stage regs load only when the preceding stage valid is high; valid regs always load
ID_W, $clog2(N_REQ) (min 1), width of the requester ID

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
req_vld  in  N_REQ  per-requester request valid
req_dat  in  N_REQ*DAT_W  packed request data, requester i at [i*DAT_W +: DAT_W]
req_rdy  out  N_REQ  per-requester accept (one-hot or zero)
out_vld  out  1  result valid
out_dat  out  DAT_W  result data
out_id  out  ID_W  requester index of the result
busy  out  1  any beat in flight in the pipe

Behaviour:
Clock and reset:
- Single clock, posedge. Reset is asynchronous, active-low (rst_n).
- On reset: all pipe valid, data and ID regs = 0; all outstanding counters = 0; rr_ptr = 0.
- Consequently out_vld=0, out_dat=0, out_id=0, busy=0.
- req_rdy is combinational and is 0 while rst_n=0.

Eligibility and grant:
- elig[i] = req_vld[i] & (cnt[i] < MAX_OUTS).
- Grant is combinational round-robin: scan i = rr_ptr, rr_ptr+1, ... mod N_REQ. The first eligible index wins.
- req_rdy = onehot(winner), or all-zero if none are eligible.
- At most one accept per cycle. The handshake is req_vld[i] & req_rdy[i].
- req_rdy never depends on req_dat.
- A requester may hold req_vld with changing data. The sampled data is whatever is present in the accept cycle.

Pointer update:
- On an accept by i: rr_ptr <= (i+1) mod N_REQ. Wrap from N_REQ-1 to 0.
- No accept: rr_ptr holds.

Pipe:
- The accept in cycle t loads stage 1 with {vld=1, dat=req_dat[i], id=i}. Cycles with no accept load vld=0.
- Each stage k+1 loads from stage k every cycle. There is no stall and no backpressure.
- out_* = stage DEPTH, so out_vld rises exactly DEPTH cycles after the accept edge.
- With LOW_PWR_OPT=1, a bubble leaves the stale dat/id in the next stage, but vld=0 there. Consumers must qualify with out_vld.
- busy = OR of all stage valids.

Outstanding counters:
- cnt[i] is ceil(log2(MAX_OUTS+1)) bits wide.
- Increments on accept by i. Decrements when out_vld & out_id==i.
- Same-cycle accept and retire for the same i: unchanged.
- cnt never exceeds MAX_OUTS and never underflows. A decrement at 0 is impossible by construction; assert it in the bench.

Boundary conditions:
- All requesters saturated (cnt=MAX_OUTS): no grant, rr_ptr holds.
- A retire in cycle t makes the requester eligible in cycle t+1, not t.
- Single eligible requester: granted every cycle until its cnt reaches MAX_OUTS.
- Reset asserted mid-flight: all in-flight beats are dropped, with no out_vld for them.
- Counters clear.
- After release, the first accept can occur in the first cycle rst_n is high.

Throughput:
- Max 1 beat/cycle aggregate.
- Per requester, at most MAX_OUTS beats per DEPTH+1 cycles.

Test Plan:
1. Reset and latency: after reset, only req 2 requests, dat=0xA, for one cycle. Required: req_rdy=0100. out_vld=1 with out_dat=0xA, out_id=2 exactly DEPTH=2 cycles later; busy=1 during the intervening cycles; cnt[2] returns to 0.
2. Round-robin fairness: all 4 requesters hold req_vld, MAX_OUTS=4. Required: grant order 0,1,2,3,0,1,...; outputs appear in the same order with matching IDs; one out_vld per cycle.
3. Credit cap: DEPTH=2, MAX_OUTS=2, only req 0 holds req_vld. Required: accepts at cycles 0,1; stall at cycle 2; out_vld at cycle 2 retires the first beat; re-accept at cycle 3; repeating pattern.
4. Same-cycle accept and retire: req 1 has cnt=1 retiring in the same cycle req 1 is accepted. Required: cnt[1] stays 1.
5. Pointer wrap and skip: rr_ptr=3, only req 0 and req 2 valid. Required: grant 0, then 2, then 0.
6. Async reset mid-flight: assert rst_n=0 asynchronously while 2 beats are in flight. Required: out_vld and busy go 0 immediately; no stale outputs after release; all counters = 0.
